// File: rtl/serial_parity_rx.sv
// serial_parity_rx
//   Receives frames of the form start(0), DATA_W data bits LSB first, one
//   parity bit, stop(1). The line idles high and is already synchronous to
//   clk. Each bit is sampled at its middle: the clock counter is aligned
//   HALF cycles into the start bit and then counts whole bit periods.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_in       serial line
//   data_out    last received word, held until the next frame completes
//   data_valid  one-cycle pulse per completed frame (errors included)
//   parity_err  parity mismatch, qualified by data_valid
//   frame_err   stop bit sampled low, qualified by data_valid
//   busy        receiver is not in IDLE
module serial_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              acc, acc_n;
    logic              perr, perr_n;
    logic [DATA_W-1:0] dout_n;
    logic              dv_n, pe_n, fe_n;
    logic [DATA_W:0]   sh_ins;
    logic              bit_end;

    // New sample enters at the MSB and moves down; after DATA_W samples the
    // first-received bit sits at bit 0.
    assign sh_ins  = {rx_in, sh};
    assign bit_end = (cnt == CNT_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            acc        <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            acc        <= acc_n;
            perr       <= perr_n;
            data_out   <= dout_n;
            data_valid <= dv_n;
            parity_err <= pe_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        acc_n   = acc;
        perr_n  = perr;
        dout_n  = data_out;
        dv_n    = 1'b0;
        pe_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_in) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (rx_in) begin
                        state_n = IDLE;       // glitch, not a start bit
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                        sh_n    = '0;
                        acc_n   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_n  = sh_ins[DATA_W:1];
                    acc_n = acc ^ rx_in;
                    idx_n = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = PARITY;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    perr_n  = acc ^ rx_in ^ PARITY_ODD;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    dout_n  = sh;
                    dv_n    = 1'b1;
                    pe_n    = perr;
                    fe_n    = ~rx_in;
                    state_n = rx_in ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A line stuck low after a bad stop bit must not look like
                // a new start bit.
                cnt_n = '0;
                if (rx_in) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial frame receiver with parity check. It is the receive end of a serial link whose transmitter builds its parity bit with an XOR reduction.
- Frame format: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1). Line idles high.
- Oversamples the line with a per-bit clock counter and samples each bit at mid-bit.
- Delivers the data word with parity and framing status to the downstream logic-gate/test datapath.

Parameters:
DATA_W, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 4, clk cycles per serial bit; even, >=2; HALF = CLKS_PER_BIT/2
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line, idle high; already synchronous to clk
data_out  output  DATA_W  last received data word; held until the next frame completes
data_valid  output  1  one-cycle pulse when a frame completes (including frames with errors)
parity_err  output  1  valid only with data_valid; 1 = parity mismatch
frame_err  output  1  valid only with data_valid; 1 = stop bit sampled 0
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE and clears data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, bit counter, clock counter, shift register and parity accumulator. Reset has priority over all other events, including mid-frame; a partial frame is discarded and produces no data_valid.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: at edge t0, if rx_in=0, go to START with clock counter=0. Otherwise stay.
- START: at t0+HALF (mid start bit), sample rx_in.
  - 0: go to DATA with counter=0 and bit index=0.
  - 1: glitch; return to IDLE. No outputs change.
- DATA: sample at t0+HALF+k*CLKS_PER_BIT for k=1..DATA_W.
  - Shift the sample into bit k-1 (LSB first).
  - parity_acc ^= sample.
  - After bit DATA_W-1, go to PARITY.
- PARITY: sample at k=DATA_W+1. perr = parity_acc ^ sample ^ PARITY_ODD. Go to STOP.
- STOP: sample at k=DATA_W+2.
  - Sample 1: go to IDLE.
  - Sample 0: go to WAIT_IDLE.
  - In both cases, on the next edge: data_out <= shift register, parity_err <= perr, frame_err <= ~sample, data_valid=1 for exactly one cycle.
- WAIT_IDLE: stay until rx_in=1, then go to IDLE. A low line here is never treated as a start bit.
- Latency: data_valid is high in the cycle after edge t0+HALF+(DATA_W+2)*CLKS_PER_BIT. With defaults, that edge is t0+42, so data_valid is high in the cycle following it.
- parity_err and frame_err return to 0 the cycle after the data_valid pulse. data_out keeps its value.
- Back-to-back frames: a start bit beginning immediately after the stop sample is detected from IDLE. No idle gap beyond the second half of the stop bit is required.
- Counters: the clock counter wraps at CLKS_PER_BIT-1 and is HALF-aligned from START. Bit index width is clog2(DATA_W+1).
- busy goes high at the edge leaving IDLE and low at the edge entering IDLE.

Test Plan:
1. Clean frame, defaults: send 0xA5 with parity 0 and stop 1 -> data_valid pulses once 43 cycles after t0; data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
2. Parity error: send 0x01 with parity 0 -> data_valid=1, data_out=0x01, parity_err=1, frame_err=0. Repeat with PARITY_ODD=1 -> parity_err=0.
3. Framing error: send 0x3C with correct parity and stop=0, holding the line low for 20 more cycles -> data_valid with frame_err=1, data_out=0x3C. FSM stays in WAIT_IDLE (busy=1) with no new frame until the line returns high. A following 0x5A frame is received cleanly.
4. Glitch: rx_in low for 1 cycle, then high -> busy=1 for HALF cycles, returns to IDLE, no data_valid.
5. Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0xFF -> all outputs 0, no data_valid. The next frame 0x3C yields data_out=0x3C with no errors.
6. Back-to-back: frames 0x12, then 0x34 with the start bit directly after the stop bit -> two data_valid pulses exactly (DATA_W+3)*CLKS_PER_BIT=44 cycles apart, with correct data and no errors.
